worley_point_ctrl: RTL and testbench

Per-frame scheduler for the Worley-noise feature points. It holds the position and velocity of every feature point and, once per video frame during vertical blanking, steps each point by its velocity, reflecting off the screen edges. The block sits between the hvsync timing generator and the noise datapath. Its registered point coordinates replace the free-running, wrap-prone `t`-derived point arithmetic, so points stay on-screen forever.

---
 rtl/worley_pkg.sv | 31 +++
 rtl/worley_axis_step.sv | 52 +++++
 rtl/worley_point_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_worley_point_ctrl.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/worley_pkg.sv
// -----------------------------------------------------------------------------
// worley_pkg
// Shared definitions for the Worley-noise feature-point scheduler:
//   - default screen limits (DEF_X_MAX / DEF_Y_MAX)
//   - reset position and velocity tables (4 entries, repeated modulo 4)
//   - FSM state enum used by worley_point_ctrl
// -----------------------------------------------------------------------------
package worley_pkg;

   localparam int DEF_X_MAX = 639;
   localparam int DEF_Y_MAX = 479;

   localparam int RST_TBL_LEN = 4;

   localparam int RST_X  [RST_TBL_LEN] = '{100, 300, 500, 100};
   localparam int RST_Y  [RST_TBL_LEN] = '{100, 200, 400, 460};
   localparam int RST_VX [RST_TBL_LEN] = '{  1,  -1,   2,  -1};
   localparam int RST_VY [RST_TBL_LEN] = '{ -1,   1,  -1,  -2};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Points beyond the table length reuse the table from the start.
   function automatic int rst_tbl_idx(input int i);
      return i % RST_TBL_LEN;
   endfunction

endpackage

// File: rtl/worley_axis_step.sv
// -----------------------------------------------------------------------------
// worley_axis_step
// Combinational single-axis integrator with edge reflection.
//   pos_i  : current coordinate (0..max_i)
//   vel_i  : signed velocity
//   max_i  : largest legal coordinate on this axis
//   pos_o  : next coordinate, reflected back into 0..max_i
//   vel_o  : next velocity, negated when a reflection happened
// Arithmetic runs at COORD_W+2 signed bits so pos+vel and 2*max-nxt never
// overflow.
// -----------------------------------------------------------------------------
module worley_axis_step #(
   parameter int COORD_W = 10,
   parameter int VEL_W   = 4
) (
   input  logic        [COORD_W-1:0] pos_i,
   input  logic signed [VEL_W-1:0]   vel_i,
   input  logic        [COORD_W-1:0] max_i,
   output logic        [COORD_W-1:0] pos_o,
   output logic signed [VEL_W-1:0]   vel_o
);

   localparam int SW = COORD_W + 2;

   logic signed [SW-1:0] pos_s;
   logic signed [SW-1:0] max_s;
   logic signed [SW-1:0] vel_s;
   logic signed [SW-1:0] nxt_s;
   logic signed [SW-1:0] refl_s;

   always_comb begin
      pos_s  = $signed({2'b00, pos_i});
      max_s  = $signed({2'b00, max_i});
      vel_s  = SW'(vel_i);               // sign-extending cast
      nxt_s  = pos_s + vel_s;
      refl_s = (max_s <<< 1) - nxt_s;

      pos_o  = COORD_W'(nxt_s);
      vel_o  = vel_i;

      if (nxt_s[SW-1]) begin
         // Went below zero: mirror around 0.
         pos_o = COORD_W'(-nxt_s);
         vel_o = -vel_i;
      end else if (nxt_s > max_s) begin
         // Went past the far edge: mirror around max.
         pos_o = COORD_W'(refl_s);
         vel_o = -vel_i;
      end
   end

endmodule

// File: rtl/worley_point_ctrl.sv
// -----------------------------------------------------------------------------
// worley_point_ctrl
// Per-frame scheduler for the Worley-noise feature points. Holds position and
// velocity of every point; on each accepted frame_tick it sweeps the points
// one per cycle, stepping each by its velocity with edge reflection.
//
// Ports:
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   frame_tick   one-cycle start pulse (vertical blanking)
//   pause        hold positions/velocities during the sweep
//   points_x     packed x coordinates, point i at [i*COORD_W +: COORD_W]
//   points_y     packed y coordinates, same packing
//   busy         high from the accepting edge until the sweep retires
//   update_done  one-cycle pulse after the last point is written
//   frame_cnt    completed-sweep count, wraps at 2^20
//   overrun      sticky: a tick arrived while not IDLE (tick dropped)
//   dbg_state_o  current FSM state
//
// Handshake: frame_tick is a fire-and-forget pulse with no ready; it is taken
// only when the FSM is IDLE at that edge, otherwise it is dropped and flagged
// on overrun. Timeline from the accepting edge E0: point i written at E(i+1),
// update_done high after E(N_POINTS), busy falls / frame_cnt bumps at
// E(N_POINTS+1).
// -----------------------------------------------------------------------------
module worley_point_ctrl
   import worley_pkg::*;
#(
   parameter int N_POINTS = 4,
   parameter int COORD_W  = 10,
   parameter int X_MAX    = DEF_X_MAX,
   parameter int Y_MAX    = DEF_Y_MAX,
   parameter int VEL_W    = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          frame_tick,
   input  logic                          pause,
   output logic [N_POINTS*COORD_W-1:0]   points_x,
   output logic [N_POINTS*COORD_W-1:0]   points_y,
   output logic                          busy,
   output logic                          update_done,
   output logic [19:0]                   frame_cnt,
   output logic                          overrun,
   output state_e                        dbg_state_o
);

   localparam int IDX_W = $clog2(N_POINTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

   // ---------------------------------------------------------------------------
   // Control FSM
   // ---------------------------------------------------------------------------
   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [19:0]        cnt_q, cnt_d;
   logic               ovr_q, ovr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      ovr_d   = ovr_q;

      unique case (state_q)
         IDLE: begin
            if (frame_tick) begin
               state_d = SWEEP;
               idx_d   = '0;
               busy_d  = 1'b1;
            end
         end
         SWEEP: begin
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
            if (frame_tick) ovr_d = 1'b1;
         end
         DONE: begin
            // A tick on this edge is still outside IDLE, so it is dropped.
            state_d = IDLE;
            busy_d  = 1'b0;
            cnt_d   = cnt_q + 20'd1;
            if (frame_tick) ovr_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Point storage and shared per-axis steppers
   // ---------------------------------------------------------------------------
   logic        [COORD_W-1:0] pos_x_q [N_POINTS];
   logic        [COORD_W-1:0] pos_y_q [N_POINTS];
   logic signed [VEL_W-1:0]   vel_x_q [N_POINTS];
   logic signed [VEL_W-1:0]   vel_y_q [N_POINTS];

   logic        [COORD_W-1:0] pos_x_d, pos_y_d;
   logic signed [VEL_W-1:0]   vel_x_d, vel_y_d;

   worley_axis_step #(
      .COORD_W (COORD_W),
      .VEL_W   (VEL_W)
   ) u_step_x (
      .pos_i (pos_x_q[idx_q]),
      .vel_i (vel_x_q[idx_q]),
      .max_i (COORD_W'(X_MAX)),
      .pos_o (pos_x_d),
      .vel_o (vel_x_d)
   );

   worley_axis_step #(
      .COORD_W (COORD_W),
      .VEL_W   (VEL_W)
   ) u_step_y (
      .pos_i (pos_y_q[idx_q]),
      .vel_i (vel_y_q[idx_q]),
      .max_i (COORD_W'(Y_MAX)),
      .pos_o (pos_y_d),
      .vel_o (vel_y_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_POINTS; i++) begin
            pos_x_q[i] <= COORD_W'(RST_X [rst_tbl_idx(i)]);
            pos_y_q[i] <= COORD_W'(RST_Y [rst_tbl_idx(i)]);
            vel_x_q[i] <= VEL_W'(RST_VX[rst_tbl_idx(i)]);
            vel_y_q[i] <= VEL_W'(RST_VY[rst_tbl_idx(i)]);
         end
      end else if (state_q == SWEEP && !pause) begin
         pos_x_q[idx_q] <= pos_x_d;
         pos_y_q[idx_q] <= pos_y_d;
         vel_x_q[idx_q] <= vel_x_d;
         vel_y_q[idx_q] <= vel_y_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs (all straight from flops)
   // ---------------------------------------------------------------------------
   for (genvar g = 0; g < N_POINTS; g++) begin : g_pack
      assign points_x[g*COORD_W +: COORD_W] = pos_x_q[g];
      assign points_y[g*COORD_W +: COORD_W] = pos_y_q[g];
   end

   assign busy        = busy_q;
   assign update_done = done_q;
   assign frame_cnt   = cnt_q;
   assign overrun     = ovr_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_worley_point_ctrl.sv
// -----------------------------------------------------------------------------
// tb_worley_point_ctrl
// Self-checking bench for worley_point_ctrl. A reference model of the points
// (plain integer arrays stepped with the reflect rules) predicts positions;
// timing of busy/update_done/frame_cnt/overrun is predicted from the sweep
// timeline. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_worley_point_ctrl;
   import worley_pkg::*;

   localparam int N  = 4;
   localparam int CW = 10;
   localparam int VW = 4;
   localparam int XM = 639;
   localparam int YM = 479;

   // ---------------------------------------------------------------------------
   // Clock / reset / DUT
   // ---------------------------------------------------------------------------
   logic            clk        = 1'b0;
   logic            rst_n      = 1'b0;
   logic            frame_tick = 1'b0;
   logic            pause      = 1'b0;
   logic [N*CW-1:0] points_x;
   logic [N*CW-1:0] points_y;
   logic            busy;
   logic            update_done;
   logic [19:0]     frame_cnt;
   logic            overrun;
   state_e          dbg_state;

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt++;

   worley_point_ctrl #(
      .N_POINTS (N),
      .COORD_W  (CW),
      .X_MAX    (XM),
      .Y_MAX    (YM),
      .VEL_W    (VW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .pause       (pause),
      .points_x    (points_x),
      .points_y    (points_y),
      .busy        (busy),
      .update_done (update_done),
      .frame_cnt   (frame_cnt),
      .overrun     (overrun),
      .dbg_state_o (dbg_state)
   );

   // ---------------------------------------------------------------------------
   // Reference model and scoreboard state
   // ---------------------------------------------------------------------------
   int tests_run    = 0;
   int tests_failed = 0;

   int mx [N];
   int my [N];
   int mvx[N];
   int mvy[N];
   int exp_cnt;
   bit exp_ovr;

   logic [N*CW-1:0] exp_q[$];

   function automatic void model_axis(inout int p, inout int v, input int lim);
      int n;
      n = p + v;
      if (n < 0) begin
         p = -n;
         v = -v;
      end else if (n > lim) begin
         p = 2 * lim - n;
         v = -v;
      end else begin
         p = n;
      end
   endfunction

   function automatic void model_reset();
      int tx [4] = '{100, 300, 500, 100};
      int ty [4] = '{100, 200, 400, 460};
      int tvx[4] = '{  1,  -1,   2,  -1};
      int tvy[4] = '{ -1,   1,  -1,  -2};
      for (int i = 0; i < N; i++) begin
         mx[i]  = tx[i % 4];
         my[i]  = ty[i % 4];
         mvx[i] = tvx[i % 4];
         mvy[i] = tvy[i % 4];
      end
      exp_cnt = 0;
      exp_ovr = 1'b0;
   endfunction

   function automatic void model_step();
      for (int i = 0; i < N; i++) begin
         model_axis(mx[i], mvx[i], XM);
         model_axis(my[i], mvy[i], YM);
      end
   endfunction

   function automatic logic [N*CW-1:0] pack_x();
      logic [N*CW-1:0] r;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(mx[i]);
      return r;
   endfunction

   function automatic logic [N*CW-1:0] pack_y();
      logic [N*CW-1:0] r;
      for (int i = 0; i < N; i++) r[i*CW +: CW] = CW'(my[i]);
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic apply_reset();
      frame_tick = 1'b0;
      pause      = 1'b0;
      rst_n      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   // Full accepted sweep with model update; waits until the FSM has retired.
   task automatic run_sweep();
      if (!pause) model_step();
      exp_cnt++;
      pulse_tick();
      repeat (N + 1) @(negedge clk);
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      apply_reset();
      tests_run++;
      if (points_x !== pack_x()) begin
         tests_failed++;
         $display("FAIL reset_x: got %h want %h", points_x, pack_x());
      end
      tests_run++;
      if (points_y !== pack_y()) begin
         tests_failed++;
         $display("FAIL reset_y: got %h want %h", points_y, pack_y());
      end
      tests_run++;
      if ({busy, update_done, overrun} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_flags: busy/done/ovr got %b%b%b want 000", busy, update_done, overrun);
      end
      tests_run++;
      if (frame_cnt !== 20'd0) begin
         tests_failed++;
         $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
      end
      tests_run++;
      if (dbg_state !== IDLE) begin
         tests_failed++;
         $display("FAIL reset_state: got %0d want IDLE", dbg_state);
      end
   endtask

   task automatic test_single_tick();
      logic [N*CW-1:0] old_x, old_y, new_x, new_y, ex, ey;
      apply_reset();
      old_x = pack_x();
      old_y = pack_y();
      model_step();
      new_x = pack_x();
      new_y = pack_y();
      pulse_tick();
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL tick_busy_e0: got %b want 1", busy);
      end
      for (int k = 1; k <= N + 1; k++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            ex[i*CW +: CW] = (k >= i + 1) ? new_x[i*CW +: CW] : old_x[i*CW +: CW];
            ey[i*CW +: CW] = (k >= i + 1) ? new_y[i*CW +: CW] : old_y[i*CW +: CW];
         end
         tests_run++;
         if (points_x !== ex || points_y !== ey) begin
            tests_failed++;
            $display("FAIL tick_pts_k%0d: got %h/%h want %h/%h", k, points_x, points_y, ex, ey);
         end
         tests_run++;
         if (update_done !== (k == N)) begin
            tests_failed++;
            $display("FAIL tick_done_k%0d: got %b want %b", k, update_done, (k == N));
         end
         tests_run++;
         if (busy !== (k <= N)) begin
            tests_failed++;
            $display("FAIL tick_busy_k%0d: got %b want %b", k, busy, (k <= N));
         end
         tests_run++;
         if (frame_cnt !== ((k >= N + 1) ? 20'd1 : 20'd0)) begin
            tests_failed++;
            $display("FAIL tick_cnt_k%0d: got %0d", k, frame_cnt);
         end
      end
      tests_run++;
      if (points_x[0 +: CW] !== 10'd101 || points_y[0 +: CW] !== 10'd99 ||
          points_x[CW +: CW] !== 10'd299 || points_y[CW +: CW] !== 10'd201) begin
         tests_failed++;
         $display("FAIL tick_consts: p0=(%0d,%0d) p1=(%0d,%0d) want (101,99) (299,201)",
                  points_x[0 +: CW], points_y[0 +: CW], points_x[CW +: CW], points_y[CW +: CW]);
      end
   endtask

   task automatic test_low_bounce();
      apply_reset();
      for (int t = 1; t <= 102; t++) begin
         run_sweep();
         if (t == 100 || t == 101 || t == 102) begin
            tests_run++;
            if (points_y[0 +: CW] !== CW'(t - 100)) begin
               tests_failed++;
               $display("FAIL low_bounce_y0_t%0d: got %0d want %0d", t, points_y[0 +: CW], t - 100);
            end
         end
      end
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y() || frame_cnt !== 20'(exp_cnt)) begin
         tests_failed++;
         $display("FAIL low_bounce_all: got %h/%h cnt %0d want %h/%h cnt %0d",
                  points_x, points_y, frame_cnt, pack_x(), pack_y(), exp_cnt);
      end
   endtask

   task automatic test_high_bounce();
      int want;
      apply_reset();
      for (int t = 1; t <= 71; t++) begin
         run_sweep();
         if (t >= 69) begin
            want = (t == 71) ? 636 : 638;
            tests_run++;
            if (points_x[2*CW +: CW] !== CW'(want)) begin
               tests_failed++;
               $display("FAIL high_bounce_x2_t%0d: got %0d want %0d", t, points_x[2*CW +: CW], want);
            end
         end
      end
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y()) begin
         tests_failed++;
         $display("FAIL high_bounce_all: got %h/%h want %h/%h", points_x, points_y, pack_x(), pack_y());
      end
   endtask

   task automatic test_overrun_pause();
      // Second tick two cycles into the sweep.
      apply_reset();
      model_step();
      pulse_tick();
      @(negedge clk);
      pulse_tick();
      repeat (N + 2) @(negedge clk);
      tests_run++;
      if (overrun !== 1'b1 || frame_cnt !== 20'd1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL overrun_mid: ovr %b cnt %0d busy %b want 1 1 0", overrun, frame_cnt, busy);
      end
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y()) begin
         tests_failed++;
         $display("FAIL overrun_pts: got %h/%h want %h/%h", points_x, points_y, pack_x(), pack_y());
      end
      // Tick on the edge that returns to IDLE is also dropped.
      apply_reset();
      model_step();
      pulse_tick();
      repeat (N) @(negedge clk);
      pulse_tick();
      tests_run++;
      if (overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL overrun_edge: got %b want 1", overrun);
      end
      repeat (N + 2) @(negedge clk);
      tests_run++;
      if (frame_cnt !== 20'd1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL overrun_edge_cnt: cnt %0d busy %b want 1 0", frame_cnt, busy);
      end
      // Pause: sweep runs, positions held.
      pause = 1'b1;
      pulse_tick();
      repeat (N + 1) @(negedge clk);
      pause = 1'b0;
      tests_run++;
      if (frame_cnt !== 20'd2) begin
         tests_failed++;
         $display("FAIL pause_cnt: got %0d want 2", frame_cnt);
      end
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y()) begin
         tests_failed++;
         $display("FAIL pause_pts: got %h/%h want %h/%h", points_x, points_y, pack_x(), pack_y());
      end
      // Velocities also held: the next unpaused sweep is a single step.
      run_sweep();
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y() || overrun !== 1'b1) begin
         tests_failed++;
         $display("FAIL pause_resume: got %h/%h ovr %b want %h/%h 1",
                  points_x, points_y, overrun, pack_x(), pack_y());
      end
   endtask

   task automatic test_reset_mid_sweep();
      bit saw_done;
      apply_reset();
      pulse_tick();
      repeat (3) @(negedge clk);
      saw_done = 1'b0;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y()) begin
         tests_failed++;
         $display("FAIL rst_mid_pts: got %h/%h want %h/%h", points_x, points_y, pack_x(), pack_y());
      end
      tests_run++;
      if ({busy, update_done, overrun} !== 3'b000 || frame_cnt !== 20'd0 || dbg_state !== IDLE) begin
         tests_failed++;
         $display("FAIL rst_mid_flags: busy %b done %b ovr %b cnt %0d st %0d",
                  busy, update_done, overrun, frame_cnt, dbg_state);
      end
      repeat (3) begin
         @(negedge clk);
         if (update_done) saw_done = 1'b1;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (update_done) saw_done = 1'b1;
      end
      tests_run++;
      if (saw_done) begin
         tests_failed++;
         $display("FAIL rst_mid_nodone: got update_done pulse want none");
      end
      run_sweep();
      tests_run++;
      if (points_x !== pack_x() || points_y !== pack_y() || frame_cnt !== 20'd1) begin
         tests_failed++;
         $display("FAIL rst_mid_after: got %h/%h cnt %0d want %h/%h cnt 1",
                  points_x, points_y, frame_cnt, pack_x(), pack_y());
      end
   endtask

   task automatic test_random();
      int gap, next_edge, last_acc;
      bit accept;
      logic [N*CW-1:0] ex;
      apply_reset();
      exp_q.delete();
      exp_q.push_back(pack_x());
      last_acc = -1000;
      for (int it = 0; it < 150; it++) begin
         gap = $urandom_range(0, 7);
         repeat (gap) @(negedge clk);
         next_edge = edge_cnt + 1;
         accept = (next_edge - last_acc) >= (N + 2);
         if (accept) begin
            ex = exp_q.pop_front();
            tests_run++;
            if (points_x !== ex || points_y !== pack_y()) begin
               tests_failed++;
               $display("FAIL rand_pts_it%0d: got %h/%h want %h/%h", it, points_x, points_y, ex, pack_y());
            end
            pause = ($urandom_range(0, 3) == 0);
            if (!pause) model_step();
            exp_cnt++;
            exp_q.push_back(pack_x());
            last_acc = next_edge;
         end else begin
            exp_ovr = 1'b1;
         end
         pulse_tick();
      end
      repeat (N + 2) @(negedge clk);
      ex = exp_q.pop_front();
      tests_run++;
      if (points_x !== ex || points_y !== pack_y()) begin
         tests_failed++;
         $display("FAIL rand_final_pts: got %h/%h want %h/%h", points_x, points_y, ex, pack_y());
      end
      tests_run++;
      if (frame_cnt !== 20'(exp_cnt) || overrun !== exp_ovr || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rand_final_flags: cnt %0d ovr %b busy %b want %0d %b 0",
                  frame_cnt, overrun, busy, exp_cnt, exp_ovr);
      end
      pause = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Sequence and report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single_tick();
      test_low_bounce();
      test_high_bounce();
      test_overrun_pause();
      test_reset_mid_sweep();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
